bcd_scan_display: RTL and testbench
===================================

// Module: bcd_scan_display
// PURPOSE
//  Output-side partner of the switch-debounce/decade-counter path: takes four BCD digits from
//  counter logic and drives one time-multiplexed, active-low 7-segment bus plus digit enables.
//  Prescaler-timed round-robin scan, one blank cycle per slot (anti-ghosting), frame-synchronous
//  double buffering so a digit update never tears mid-frame. Sits between counter regs and pins.
// PARAMETERS
//  SCAN_DIV  50000  clocks per digit slot (1 kHz slot at 50 MHz); legal range >= 2
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  bcd_in     in   16  four BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3
//  load       in   1   1-cycle strobe: capture bcd_in into pending buffer
//  seg_n      out  7   segments {g,f,e,d,c,b,a}, active-low, registered
//  dig_en_n   out  4   digit enables, one-hot active-low, registered; bit i = digit i
//  frame_tick out  1   1-cycle pulse on the edge that commits pending->active (frame end)
// BEHAVIOUR
//  - Reset (async, any time): cnt=0, idx=0, pending=16'h0, active=16'h0, seg_n=7'h7F,
//    dig_en_n=4'hF, frame_tick=0. Mid-scan reset aborts immediately; scan restarts at digit 0.
//  - Prescaler cnt: 0..SCAN_DIV-1, wraps to 0; on wrap idx advances 0->1->2->3->0.
//    Width = $clog2(SCAN_DIV). No other way to advance idx.
//  - Slot states (decoded from cnt): BLANK when cnt==0, SHOW when cnt 1..SCAN_DIV-1.
//  - Outputs lag (cnt,idx) by exactly one clock:
//    BLANK -> seg_n=7'h7F, dig_en_n=4'hF; SHOW -> dig_en_n=~(4'b1<<idx), seg_n=decode(active[idx]).
//    First edge after reset release drives blank; second edge drives digit0.
//  - Decode (active-low, gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//    Non-BCD nibble A..F -> 7'h3F (segment g only, "-"): error indicator, never blank.
//  - Buffering: load=1 -> pending<=bcd_in on that edge; later loads overwrite (last wins).
//    Frame end = edge where idx==3 && cnt==SCAN_DIV-1: active<=pending, frame_tick<=1.
//    load coincident with frame end: active<=bcd_in (bypass), pending<=bcd_in.
//    active never changes at any other edge, so one frame always shows one consistent value.
//  - frame_tick fires every 4*SCAN_DIV clocks regardless of load; it is a pulse, not a level.
//  - No handshake backpressure: load always accepted, no busy output.
// CONFIGURATION
//  LZB_EN defined: leading-zero blanking. In SHOW, digit i is blanked (seg_n=7'h7F,
//    dig_en_n still asserted) when active digits i..3 are all 4'h0 and i!=0; digit0 is
//    always shown. Non-BCD nibbles count as non-zero. Evaluated from active only.
//  LZB_EN undefined: every digit shown, zeros drawn as 7'h40. No extra logic synthesized.
// TESTING  (SCAN_DIV=4, frame=16 clocks)
//  1 Reset mid-SHOW of digit2 -> same cycle seg_n=7F, dig_en_n=F; after release edge1 blank,
//    edge2 dig_en_n=E with seg_n=40.
//  2 load bcd_in=16'h1234, run 2 frames -> after frame_tick slots show 30,24,79,24? no:
//    digit0=4->19, digit1=3->30, digit2=2->24, digit3=1->79; each slot = 1 blank + 3 show cycles.
//  3 load 16'h0009 then 16'h0005 in same frame -> next frame shows 5 (7'h12) on digit0;
//    9 never displayed; load on frame-end edge with 16'h0007 -> next frame shows 7 (7'h78).
//  4 bcd_in=16'hA0F0 -> digits 3 and 1 show 7'h3F; digits 2,0 show 7'h40; no X on outputs.
//  5 LZB_EN, active=16'h0008 -> digits 3..1 seg_n=7F with enables cycling, digit0=7'h00;
//    active=16'h0000 -> only digit0 lit with 7'h40; LZB_EN undefined -> all four show 40.
//  6 Free-run 10 frames, no load -> frame_tick period exactly 16 clocks, one-hot dig_en_n
//    sequence E,D,B,7 repeating, never two enables low in one cycle.

Source files
------------

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: four-digit multiplexed active-low 7-segment scanner with blank slots and frame-synchronous double buffering (define LZB_EN for leading-zero blanking)
module bcd_scan_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg_n,
  output logic [3:0]  dig_en_n,
  output logic        frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_q, pend_d, act_q, act_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          tick_q, tick_d;
  logic          wrap, frame_end, lz;
  logic [3:0]    nib;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  endfunction
  always_comb begin
    wrap      = cnt_q == CW'(SCAN_DIV - 1);
    frame_end = wrap && idx_q == 2'd3;
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    idx_d     = wrap ? idx_q + 1'b1 : idx_q;
    pend_d    = load ? bcd_in : pend_q;
    act_d     = frame_end ? pend_d : act_q;
    tick_d    = frame_end;
    nib       = act_q[idx_q*4 +: 4];
`ifdef LZB_EN
    lz        = idx_q != 2'd0 && (act_q >> (4 * idx_q)) == 16'h0;
`else
    lz        = 1'b0;
`endif
    seg_d     = (cnt_q == '0 || lz) ? 7'h7F : dec(nib);
    dig_d     = cnt_q == '0 ? 4'hF : ~(4'b1 << idx_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
      seg_q  <= 7'h7F;
      dig_q  <= 4'hF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      tick_q <= tick_d;
    end
  assign seg_n      = seg_q;
  assign dig_en_n   = dig_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed plus random stimulus against a time-position model of the scanner
module tb_bcd_scan_display;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic        load = 1'b0;
  logic [6:0]  seg_n;
  logic [3:0]  dig_en_n;
  logic        frame_tick;
  int n_chk = 0;
  int n_pass = 0;
  int k = 0;
  logic [15:0] m_pend = 16'h0;
  logic [15:0] m_act = 16'h0;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic [3:0] en_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  bcd_scan_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .seg_n(seg_n), .dig_en_n(dig_en_n), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, k);
  endtask
  task automatic step(input logic ld, input logic [15:0] v);
    int p, slot, ph, d;
    logic [6:0] es;
    logic [3:0] ed;
    load = ld;
    bcd_in = v;
    p = k % 16;
    slot = p / 4;
    ph = p % 4;
    d = (int'(m_act) >> (4 * slot)) & 15;
    es = seg_tab[d];
`ifdef LZB_EN
    if (slot != 0 && (int'(m_act) >> (4 * slot)) == 0) es = 7'h7F;
`endif
    if (ph == 0) es = 7'h7F;
    ed = ph == 0 ? 4'hF : en_tab[slot];
    @(posedge clk);
    #1;
    chk("seg_n", 16'(seg_n), 16'(es));
    chk("dig_en_n", 16'(dig_en_n), 16'(ed));
    chk("frame_tick", 16'(frame_tick), 16'(p == 15));
    if (ld) m_pend = v;
    if (p == 15) m_act = m_pend;
    k++;
    load = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask
  task automatic reset_model();
    k = 0;
    m_pend = 16'h0;
    m_act = 16'h0;
  endtask
  initial begin
    #12;
    chk("rst_seg", 16'(seg_n), 16'h7F);
    chk("rst_dig", 16'(dig_en_n), 16'hF);
    chk("rst_tick", 16'(frame_tick), 16'h0);
    rst_n = 1'b1;
    reset_model();
    step(1'b1, 16'h4321);
    run(35);
    while (k % 16 != 10) step(1'b0, 16'h0);
    chk("pre_rst_dig2", 16'(dig_en_n), 16'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", 16'(seg_n), 16'h7F);
    chk("mid_rst_dig", 16'(dig_en_n), 16'hF);
    chk("mid_rst_tick", 16'(frame_tick), 16'h0);
    repeat (2) @(posedge clk);
    #3;
    chk("hold_rst_dig", 16'(dig_en_n), 16'hF);
    rst_n = 1'b1;
    reset_model();
    run(2);
    chk("rel_edge2_seg", 16'(seg_n), 16'h40);
    chk("rel_edge2_dig", 16'(dig_en_n), 16'hE);
    step(1'b1, 16'h1234);
    run(40);
    step(1'b1, 16'h0009);
    step(1'b1, 16'h0005);
    run(40);
    while (k % 16 != 15) step(1'b0, 16'h0);
    step(1'b1, 16'h0007);
    run(20);
    step(1'b1, 16'hA0F0);
    run(40);
    step(1'b1, 16'h0008);
    run(40);
    step(1'b1, 16'h0000);
    run(40);
    for (int i = 0; i < 800; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int j = 0; j < 4; j++) r[j*4 +: 4] = 4'($urandom_range(0, 9));
      step($urandom_range(0, 9) == 0, r);
    end
    run(160);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
